// File: rtl/cp0_exception_sequencer_if.sv
// cp0_exception_sequencer_if: MEM-stage request, CP0 state, CP0 write port and PC redirect bundle
//  slave  : the sequencer (requests/CP0 state in, control/write port/redirect out)
//  master : the surrounding pipeline / CP0 file / PC mux
interface cp0_exception_sequencer_if;
  logic [6:0]  exc_flags;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_req;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        stall;
  logic        flush;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  modport slave (
    input  exc_flags, exc_pc, exc_bd, exc_badvaddr, eret_req, hw_int, status_in, cause_in, epc_in,
    output stall, flush, cp0_we, cp0_waddr, cp0_wdata, redirect, redirect_pc, busy
  );
  modport master (
    output exc_flags, exc_pc, exc_bd, exc_badvaddr, eret_req, hw_int, status_in, cause_in, epc_in,
    input  stall, flush, cp0_we, cp0_waddr, cp0_wdata, redirect, redirect_pc, busy
  );
endinterface

// File: rtl/cp0_exception_sequencer.sv
// cp0_exception_sequencer: sequences one exception/interrupt/ERET through flush, CP0 writes and PC redirect
//  clk    : clock, all state on rising edge
//  resetn : asynchronous active-low reset
//  bus    : slave side of cp0_exception_sequencer_if (requests, CP0 state, write port, redirect)
//  Optional macro EXC_INT_SYNC_EN: hw_int passes through a 2-flop synchronizer before use.
module cp0_exception_sequencer #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter logic [4:0]  EPC_ADDR    = 5'd14,
  parameter logic [4:0]  BADV_ADDR   = 5'd8,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  STATUS_ADDR = 5'd12
) (
  input logic clk,
  input logic resetn,
  cp0_exception_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FLUSH, WR_EPC, WR_BADV, WR_CAUSE, WR_STATUS, REDIRECT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, badv_q, badv_d, status_q, status_d;
  logic        bd_q, bd_d, eret_q, eret_d;
  logic [4:0]  code_q, code_d, exc_code;
  logic        busy_q, busy_d, flush_q, flush_d, we_q, we_d, redirect_q, redirect_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, rpc_q, rpc_d;
  logic [5:0]  hw;
  logic        int_pend, exc_any, exl, badv_en;
  logic [31:0] epc_wd, cause_wd, status_wd;
  logic        unused_ok;
`ifdef EXC_INT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.hw_int;
      sync2_q <= sync1_q;
    end
  assign hw = sync2_q;
`else
  assign hw = bus.hw_int;
`endif
  assign unused_ok = ^{bus.cause_in[30:10], bus.cause_in[7:0]};
  assign int_pend  = bus.status_in[0] & ~bus.status_in[1] & |({hw, bus.cause_in[9:8]} & bus.status_in[15:8]);
  assign exc_any   = |bus.exc_flags;
  assign exl       = status_q[1];
  assign badv_en   = ~eret_q & (code_q == 5'd4 || code_q == 5'd5);
  assign exc_code  = bus.exc_flags[0] ? 5'd4  : bus.exc_flags[1] ? 5'd10 : bus.exc_flags[2] ? 5'd12 :
                     bus.exc_flags[3] ? 5'd8  : bus.exc_flags[4] ? 5'd9  : bus.exc_flags[5] ? 5'd4 : 5'd5;
  // While idle the request context is tracked every cycle; it freezes once the sequence starts.
  // Fetch faults resolve BadVAddr to the PC here, and a misaligned ERET becomes an AdEL-fetch.
  always_comb begin
    pc_d     = pc_q;
    bd_d     = bd_q;
    badv_d   = badv_q;
    status_d = status_q;
    eret_d   = eret_q;
    code_d   = code_q;
    if (state_q == IDLE) begin
      pc_d     = bus.exc_pc;
      bd_d     = bus.exc_bd;
      badv_d   = (!int_pend && bus.exc_flags[0]) ? bus.exc_pc : bus.exc_badvaddr;
      status_d = bus.status_in;
      eret_d   = 1'b0;
      code_d   = (!int_pend && exc_any) ? exc_code : 5'd0;
      if (!int_pend && !exc_any && bus.eret_req) begin
        pc_d   = bus.epc_in;
        badv_d = bus.epc_in;
        bd_d   = 1'b0;
        eret_d = bus.epc_in[1:0] == 2'b00;
        code_d = 5'd4;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = (int_pend | exc_any | bus.eret_req) ? FLUSH : IDLE;
      FLUSH:     state_d = eret_q ? WR_STATUS : exl ? (badv_en ? WR_BADV : WR_CAUSE) : WR_EPC;
      WR_EPC:    state_d = badv_en ? WR_BADV : WR_CAUSE;
      WR_BADV:   state_d = WR_CAUSE;
      WR_CAUSE:  state_d = WR_STATUS;
      WR_STATUS: state_d = REDIRECT;
      default:   state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so that every output is a flop.
  always_comb begin
    epc_wd     = bd_q ? pc_q - 32'd4 : pc_q;
    cause_wd   = {exl ? bus.cause_in[31] : bd_q, 15'b0, hw, bus.cause_in[9:8], 1'b0, code_q, 2'b0};
    status_wd  = eret_q ? (status_q & ~32'd2) : (status_q | 32'd2);
    busy_d     = state_d != IDLE;
    flush_d    = state_d == FLUSH;
    we_d       = state_d inside {WR_EPC, WR_BADV, WR_CAUSE, WR_STATUS};
    waddr_d    = state_d == WR_EPC ? EPC_ADDR : state_d == WR_BADV ? BADV_ADDR :
                 state_d == WR_CAUSE ? CAUSE_ADDR : state_d == WR_STATUS ? STATUS_ADDR : 5'd0;
    wdata_d    = state_d == WR_EPC ? epc_wd : state_d == WR_BADV ? badv_q :
                 state_d == WR_CAUSE ? cause_wd : state_d == WR_STATUS ? status_wd : 32'd0;
    redirect_d = state_d == REDIRECT;
    rpc_d      = !redirect_d ? 32'd0 : eret_q ? pc_q : EXC_VECTOR;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      badv_q     <= '0;
      status_q   <= '0;
      eret_q     <= 1'b0;
      code_q     <= '0;
      busy_q     <= 1'b0;
      flush_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bd_q       <= bd_d;
      badv_q     <= badv_d;
      status_q   <= status_d;
      eret_q     <= eret_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
      flush_q    <= flush_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
    end
  assign bus.busy        = busy_q;
  assign bus.stall       = busy_q;
  assign bus.flush       = flush_q;
  assign bus.cp0_we      = we_q;
  assign bus.cp0_waddr   = waddr_q;
  assign bus.cp0_wdata   = wdata_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = rpc_q;
endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// tb_cp0_exception_sequencer: model-checked random and directed stimulus for cp0_exception_sequencer
module tb_cp0_exception_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  cp0_exception_sequencer_if bus();
  cp0_exception_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic busy, flush, we;
    logic [4:0] a;
    logic [31:0] d;
    logic rd;
    logic [31:0] rpc;
  } ex_t;
  ex_t q[$];
  ex_t cur = '0;
  int codes[7] = '{4, 10, 12, 8, 9, 4, 5};
  int flush_at, redir_at;
  logic [31:0] rpc_seen;
  logic [31:0] wd[32];
  logic [31:0] wmask;
  function automatic ex_t mk(logic fl, logic we, logic [4:0] a, logic [31:0] d, logic rd, logic [31:0] rpc);
    ex_t e;
    e = '{busy: 1'b1, flush: fl, we: we, a: a, d: d, rd: rd, rpc: rpc};
    return e;
  endfunction
  function automatic logic [73:0] dut_vec();
    return {bus.busy, bus.stall, bus.flush, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.redirect, bus.redirect_pc};
  endfunction
  task automatic chk(string nm, logic [73:0] act, logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference: a request becomes a list of per-cycle outcomes (flush, each register write, redirect).
  task automatic model_sample();
    logic [31:0] st, ca, pc, bv;
    logic [5:0] hw;
    logic bd, ipend, have, er;
    logic [4:0] code;
    int idx;
    st = bus.status_in; ca = bus.cause_in; hw = bus.hw_int;
    pc = bus.exc_pc; bd = bus.exc_bd; bv = bus.exc_badvaddr;
    ipend = st[0] & ~st[1] & |({hw, ca[9:8]} & st[15:8]);
    have = 1'b1; er = 1'b0; code = 5'd0; idx = 0;
    if (ipend) code = 5'd0;
    else if (bus.exc_flags != 0) begin
      for (int i = 6; i >= 0; i--) if (bus.exc_flags[i]) idx = i;
      code = 5'(codes[idx]);
      if (idx == 0) bv = pc;
    end else if (bus.eret_req) begin
      if (bus.epc_in[1:0] != 2'b00) begin
        code = 5'd4; pc = bus.epc_in; bv = bus.epc_in; bd = 1'b0;
      end else er = 1'b1;
    end else have = 1'b0;
    if (!have) return;
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    if (er) begin
      q.push_back(mk(0, 1, 5'd12, st & ~32'd2, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 1, bus.epc_in));
      return;
    end
    if (!st[1]) q.push_back(mk(0, 1, 5'd14, bd ? pc - 32'd4 : pc, 0, 0));
    if (code == 5'd4 || code == 5'd5) q.push_back(mk(0, 1, 5'd8, bv, 0, 0));
    q.push_back(mk(0, 1, 5'd13, {st[1] ? ca[31] : bd, 15'b0, hw, ca[9:8], 1'b0, code, 2'b0}, 0, 0));
    q.push_back(mk(0, 1, 5'd12, st | 32'd2, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 32'hBFC00380));
  endtask
  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      cur = '0;
    end else begin
      if (q.size() == 0 && !cur.busy) model_sample();
      cur = (q.size() != 0) ? q.pop_front() : '0;
    end
  end
  always @(negedge clk)
    chk("cycle", dut_vec(), {cur.busy, cur.busy, cur.flush, cur.we, cur.a, cur.d, cur.rd, cur.rpc});
  task automatic idle_inputs();
    bus.exc_flags = '0; bus.exc_pc = '0; bus.exc_bd = 1'b0; bus.exc_badvaddr = '0; bus.eret_req = 1'b0;
    bus.hw_int = '0; bus.status_in = '0; bus.cause_in = '0; bus.epc_in = '0;
  endtask
  // Apply one request for one cycle, keep CP0 state held while busy, record what the DUT does.
  task automatic run_req(logic [6:0] f, logic [31:0] pc, logic bd, logic [31:0] bv, logic er,
                         logic [5:0] hw, logic [31:0] st, logic [31:0] ca, logic [31:0] ep);
    @(negedge clk); #1;
    bus.exc_flags = f; bus.exc_pc = pc; bus.exc_bd = bd; bus.exc_badvaddr = bv; bus.eret_req = er;
    bus.hw_int = hw; bus.status_in = st; bus.cause_in = ca; bus.epc_in = ep;
    flush_at = -1; redir_at = -1; rpc_seen = '0; wmask = '0;
    for (int i = 0; i < 32; i++) wd[i] = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin bus.exc_flags = '0; bus.eret_req = 1'b0; end
      if (bus.flush && flush_at < 0) flush_at = k;
      if (bus.cp0_we) begin wmask[bus.cp0_waddr] = 1'b1; wd[bus.cp0_waddr] = bus.cp0_wdata; end
      if (bus.redirect) begin
        redir_at = k; rpc_seen = bus.redirect_pc;
        idle_inputs();
        break;
      end
      if (!bus.busy) break;
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", dut_vec(), '0);
    resetn = 1'b1;
    run_req(7'h08, 32'hBFC00100, 0, 0, 0, 0, 32'h0000FF01, 0, 0);
    chk("t1_flush_at", 74'(flush_at), 74'(1));
    chk("t1_epc", wd[14], 32'hBFC00100);
    chk("t1_cause", wd[13], 32'h00000020);
    chk("t1_status", wd[12], 32'h0000FF03);
    chk("t1_no_badv", 74'(wmask[8]), 0);
    chk("t1_redir_at", 74'(redir_at), 74'(5));
    chk("t1_rpc", rpc_seen, 32'hBFC00380);
    run_req(7'h40, 32'h80001000, 1, 32'h80002003, 0, 0, 32'h0000FF01, 0, 0);
    chk("t2_epc", wd[14], 32'h80000FFC);
    chk("t2_badv", wd[8], 32'h80002003);
    chk("t2_cause", wd[13], 32'h80000014);
    chk("t2_redir_at", 74'(redir_at), 74'(6));
    run_req(7'h08, 32'h80000200, 0, 0, 0, 6'b000001, 32'h00000401, 0, 0);
    chk("t3_int_cause", wd[13], 32'h00000400);
    chk("t3_int_redir_at", 74'(redir_at), 74'(5));
    run_req(7'h00, 32'h80000200, 0, 0, 0, 6'b000001, 32'h00000403, 0, 0);
    chk("t3_exl_no_writes", wmask, 0);
    chk("t3_exl_no_redir", 74'(redir_at + 1), 0);
    idle_inputs();
    run_req(0, 0, 0, 0, 1, 0, 32'h0000FF03, 0, 32'hBFC00704);
    chk("t4_eret_status", wd[12], 32'h0000FF01);
    chk("t4_eret_writes", wmask, 32'h00001000);
    chk("t4_eret_redir_at", 74'(redir_at), 74'(3));
    chk("t4_eret_rpc", rpc_seen, 32'hBFC00704);
    run_req(0, 0, 0, 0, 1, 0, 32'h0000FF01, 0, 32'hBFC00706);
    chk("t4_adel_epc", wd[14], 32'hBFC00706);
    chk("t4_adel_badv", wd[8], 32'hBFC00706);
    chk("t4_adel_cause", wd[13], 32'h00000010);
    chk("t4_adel_rpc", rpc_seen, 32'hBFC00380);
    run_req(7'h04, 32'h80003000, 0, 0, 0, 0, 32'h0000FF03, 32'h80000000, 0);
    chk("t5_no_epc", 74'(wmask[14]), 0);
    chk("t5_cause", wd[13], 32'h80000030);
    chk("t5_redir_at", 74'(redir_at), 74'(4));
    @(negedge clk); #1;
    bus.exc_flags = 7'h08; bus.exc_pc = 32'hBFC00100; bus.status_in = 32'h0000FF01;
    found = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (k == 1) bus.exc_flags = '0;
      if (bus.cp0_we && bus.cp0_waddr == 5'd13) begin found = 1'b1; break; end
    end
    chk("t6_reached_cause", 74'(found), 74'(1));
    resetn = 1'b0;
    q.delete();
    cur = '0;
    #1;
    chk("t6_async_zero", dut_vec(), '0);
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    run_req(7'h08, 32'hBFC00100, 0, 0, 0, 0, 32'h0000FF01, 0, 0);
    chk("t6_after_status", wd[12], 32'h0000FF03);
    chk("t6_after_redir_at", 74'(redir_at), 74'(5));
    for (int n = 0; n < 300; n++) begin
      logic [6:0] f;
      logic [31:0] ep;
      f  = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
      ep = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      run_req(f, $urandom, 1'($urandom), $urandom, $urandom_range(0, 2) == 0,
              ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, $urandom, $urandom, ep);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
